// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - PC owner, icache fetch issue and DEPTH-entry predicted instruction queue
module fetch_queue #(
  parameter int          DEPTH        = 8,
  parameter logic [31:0] RESET_PC     = 32'h0,
  parameter int          PREDICT_MODE = 1
) (
  input  logic                     clockIn,
  input  logic                     resetIn,
  input  logic                     flushIn,
  input  logic [31:0]              flushPc,
  output logic                     fetchValid,
  output logic [31:0]              fetchAddr,
  input  logic                     instrInValid,
  input  logic [31:0]              instrIn,
  input  logic [31:0]              instrAddr,
  output logic                     outValid,
  output logic [31:0]              outInstr,
  output logic [31:0]              outAddr,
  output logic                     outPredTaken,
  output logic [31:0]              outPredTarget,
  input  logic                     outReady,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int             PW   = $clog2(DEPTH);
  localparam int             CW   = PW + 1;
  localparam logic [CW-1:0]  FULL = CW'(DEPTH);

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  logic [31:0]   pc_q, pc_d;
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          wait_jalr_q, wait_jalr_d;

  logic [31:0]   instr_mem_q  [DEPTH];
  logic [31:0]   addr_mem_q   [DEPTH];
  logic          taken_mem_q  [DEPTH];
  logic [31:0]   target_mem_q [DEPTH];

  logic          full;
  logic          deq;
  logic          accept;
  logic [31:0]   j_imm;
  logic [31:0]   b_imm;
  logic          pred_taken;
  logic [31:0]   pred_target;
  logic          set_wait;

  // Queue handshakes: a response is only taken if it matches the live PC and there is room
  always_comb begin
    full   = (count_q == FULL);
    deq    = (count_q != '0) && outReady;
    accept = instrInValid && !flushIn && !wait_jalr_q && (instrAddr == pc_q) && (!full || deq);
  end

  // Static prediction of the returned instruction; predTarget doubles as the next PC
  always_comb begin
    j_imm       = {{12{instrIn[31]}}, instrIn[19:12], instrIn[20], instrIn[30:21], 1'b0};
    b_imm       = {{20{instrIn[31]}}, instrIn[7], instrIn[30:25], instrIn[11:8], 1'b0};
    pred_taken  = 1'b0;
    pred_target = pc_q + 32'd4;
    set_wait    = 1'b0;
    case (instrIn[6:0])
      OP_JAL: begin
        pred_taken  = 1'b1;
        pred_target = pc_q + j_imm;
      end
      OP_BRANCH: begin
        if (PREDICT_MODE == 1 && b_imm[31]) begin
          pred_taken  = 1'b1;
          pred_target = pc_q + b_imm;
        end
      end
      OP_JALR: set_wait = 1'b1;
      default: ;
    endcase
  end

  // Next-state: flush wipes the queue and discards any same-cycle enqueue/dequeue
  always_comb begin
    pc_d        = pc_q;
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    wait_jalr_d = wait_jalr_q;
    if (flushIn) begin
      pc_d        = flushPc;
      head_d      = '0;
      tail_d      = '0;
      count_d     = '0;
      wait_jalr_d = 1'b0;
    end else begin
      if (deq) head_d = head_q + PW'(1);
      if (accept) begin
        tail_d      = tail_q + PW'(1);
        pc_d        = set_wait ? pc_q : pred_target;
        wait_jalr_d = set_wait;
      end
      count_d = count_q + CW'(accept) - CW'(deq);
    end
  end

  // Control state registers with synchronous reset taking priority over everything
  always_ff @(posedge clockIn) begin
    if (resetIn) begin
      pc_q        <= RESET_PC;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      wait_jalr_q <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      wait_jalr_q <= wait_jalr_d;
    end
  end

  // Entry storage written at the tail on accept; contents need no reset
  always_ff @(posedge clockIn) begin
    if (accept && !resetIn) begin
      instr_mem_q[tail_q]  <= instrIn;
      addr_mem_q[tail_q]   <= instrAddr;
      taken_mem_q[tail_q]  <= pred_taken;
      target_mem_q[tail_q] <= pred_target;
    end
  end

  assign fetchValid    = !resetIn && !wait_jalr_q && !full;
  assign fetchAddr     = pc_q;
  assign outValid      = (count_q != '0);
  assign outInstr      = instr_mem_q[head_q];
  assign outAddr       = addr_mem_q[head_q];
  assign outPredTaken  = taken_mem_q[head_q];
  assign outPredTarget = target_mem_q[head_q];
  assign count         = count_q;

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - scoreboard bench for fetch_queue
module tb_fetch_queue;

  localparam int DEPTH = 8;
  localparam logic [31:0] ADDI = 32'h00100093;
  localparam logic [31:0] JALR = 32'h000080e7;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] addr;
    logic        tk;
    logic [31:0] tgt;
  } ent_t;

  logic        clockIn = 1'b0;
  logic        resetIn = 1'b1;
  logic        flushIn = 1'b0;
  logic [31:0] flushPc = 32'h0;
  logic        instrInValid = 1'b0;
  logic [31:0] instrIn = 32'h0;
  logic [31:0] instrAddr = 32'h0;
  logic        outReady = 1'b0;

  logic        fetchValid, outValid, outPredTaken;
  logic [31:0] fetchAddr, outInstr, outAddr, outPredTarget;
  logic [3:0]  count;
  logic        fetchValid0, outValid0, outPredTaken0;
  logic [31:0] fetchAddr0, outInstr0, outAddr0, outPredTarget0;
  logic [3:0]  count0;

  int errors = 0;
  int checks = 0;

  ent_t        sb[$];
  logic [31:0] m_pc = 32'h100;
  int          m_count = 0;
  logic        m_wait = 1'b0;

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h100), .PREDICT_MODE(1)) u_dut (
    .clockIn(clockIn), .resetIn(resetIn), .flushIn(flushIn), .flushPc(flushPc),
    .fetchValid(fetchValid), .fetchAddr(fetchAddr),
    .instrInValid(instrInValid), .instrIn(instrIn), .instrAddr(instrAddr),
    .outValid(outValid), .outInstr(outInstr), .outAddr(outAddr),
    .outPredTaken(outPredTaken), .outPredTarget(outPredTarget),
    .outReady(outReady), .count(count)
  );

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h100), .PREDICT_MODE(0)) u_dut0 (
    .clockIn(clockIn), .resetIn(resetIn), .flushIn(flushIn), .flushPc(flushPc),
    .fetchValid(fetchValid0), .fetchAddr(fetchAddr0),
    .instrInValid(instrInValid), .instrIn(instrIn), .instrAddr(instrAddr),
    .outValid(outValid0), .outInstr(outInstr0), .outAddr(outAddr0),
    .outPredTaken(outPredTaken0), .outPredTarget(outPredTarget0),
    .outReady(outReady), .count(count0)
  );

  always #5 clockIn = ~clockIn;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [31:0] enc_b(input logic [12:0] imm);
    return {imm[12], imm[10:5], 5'd0, 5'd0, 3'b000, imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_j(input logic [20:0] imm);
    return {imm[20], imm[10:1], imm[11], imm[19:12], 5'd1, 7'b1101111};
  endfunction

  task automatic predict(input logic [31:0] ins, input logic [31:0] pc,
                         output logic tk, output logic [31:0] tgt, output logic wj);
    logic [31:0] immv;
    tk = 1'b0; wj = 1'b0; tgt = pc + 32'd4;
    case (ins[6:0])
      7'b1101111: begin
        immv = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
        tk = 1'b1; tgt = pc + immv;
      end
      7'b1100011: begin
        immv = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        if (immv[31]) begin tk = 1'b1; tgt = pc + immv; end
      end
      7'b1100111: wj = 1'b1;
      default: ;
    endcase
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  // One clock: drive inputs, check state against the model, update model, advance.
  task automatic cycle(input logic iv, input logic [31:0] ins, input logic [31:0] ia,
                       input logic ordy, input logic fl, input logic [31:0] fpc);
    ent_t e;
    logic tk, wj, deq, acc;
    logic [31:0] tgt;
    instrInValid = iv; instrIn = ins; instrAddr = ia;
    outReady = ordy; flushIn = fl; flushPc = fpc;
    chk("count", 32'(count), 32'(m_count));
    chk("fetchAddr", fetchAddr, m_pc);
    chk("fetchValid", 32'(fetchValid), 32'(!m_wait && m_count < DEPTH));
    chk("outValid", 32'(outValid), 32'(m_count != 0));
    deq = (m_count != 0) && ordy;
    if (deq && !fl) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL scoreboard_empty: dequeue with no expected entry");
      end else begin
        e = sb.pop_front();
        checks++;
        if ({outInstr, outAddr, outPredTaken, outPredTarget} !== e) begin
          errors++;
          $display("FAIL head_entry: got instr=%h addr=%h tk=%b tgt=%h expected instr=%h addr=%h tk=%b tgt=%h",
                   outInstr, outAddr, outPredTaken, outPredTarget, e.instr, e.addr, e.tk, e.tgt);
        end
      end
    end
    if (fl) begin
      sb.delete(); m_count = 0; m_pc = fpc; m_wait = 1'b0;
    end else begin
      acc = iv && !m_wait && (ia == m_pc) && (m_count < DEPTH || deq);
      if (acc) begin
        predict(ins, m_pc, tk, tgt, wj);
        e.instr = ins; e.addr = ia; e.tk = tk; e.tgt = tgt;
        sb.push_back(e);
        if (!wj) m_pc = tgt;
        m_wait = wj;
      end
      m_count = m_count + int'(acc) - int'(deq);
    end
    @(posedge clockIn); #1;
    instrInValid = 1'b0; outReady = 1'b0; flushIn = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clockIn);
    #1;
    chk("rst_fetchValid", 32'(fetchValid), 32'd0);
    chk("rst_outValid", 32'(outValid), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    resetIn = 1'b0;
    #1;
    chk("rst_fetchAddr", fetchAddr, 32'h100);
    chk("rst_fetchValid_after", 32'(fetchValid), 32'd1);
  endtask

  task automatic test_fill();
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, ADDI, 32'h100 + 32'(4 * i), 1'b0, 1'b0, 32'h0);
    chk("fill_count", 32'(count), 32'd8);
    chk("fill_fetchValid", 32'(fetchValid), 32'd0);
    chk("fill_fetchAddr", fetchAddr, 32'h120);
  endtask

  task automatic test_full_simul();
    chk("full_head_before", outAddr, 32'h100);
    cycle(1'b1, ADDI, 32'h120, 1'b1, 1'b0, 32'h0);
    chk("full_count", 32'(count), 32'd8);
    chk("full_head_after", outAddr, 32'h104);
    chk("full_fetchAddr", fetchAddr, 32'h124);
  endtask

  task automatic test_stale();
    repeat (3) cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
    cycle(1'b1, ADDI, 32'h200, 1'b0, 1'b0, 32'h0);
    chk("stale_count", 32'(count), 32'd5);
    chk("stale_fetchAddr", fetchAddr, 32'h124);
  endtask

  task automatic test_flush();
    chk("flush_pre_count", 32'(count), 32'd5);
    cycle(1'b1, ADDI, 32'h124, 1'b1, 1'b1, 32'h200);
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_outValid", 32'(outValid), 32'd0);
    chk("flush_fetchAddr", fetchAddr, 32'h200);
  endtask

  task automatic test_branch();
    cycle(1'b1, enc_b(13'h1FF0), 32'h200, 1'b0, 1'b0, 32'h0);
    chk("br1_fetchAddr", fetchAddr, 32'h1F0);
    chk("br1_predTaken", 32'(outPredTaken), 32'd1);
    chk("br1_predTarget", outPredTarget, 32'h1F0);
    chk("br0_fetchAddr", fetchAddr0, 32'h204);
    chk("br0_predTaken", 32'(outPredTaken0), 32'd0);
    chk("br0_predTarget", outPredTarget0, 32'h204);
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
  endtask

  task automatic test_jal_jalr();
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h300);
    cycle(1'b1, enc_j(21'h40), 32'h300, 1'b0, 1'b0, 32'h0);
    chk("jal_fetchAddr", fetchAddr, 32'h340);
    chk("jal_predTarget", outPredTarget, 32'h340);
    cycle(1'b1, JALR, 32'h340, 1'b0, 1'b0, 32'h0);
    repeat (10) cycle(1'b1, ADDI, 32'h340, 1'b0, 1'b0, 32'h0);
    chk("jalr_fetchValid", 32'(fetchValid), 32'd0);
    chk("jalr_count", 32'(count), 32'd2);
    repeat (2) cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h500);
    chk("jalr_flush_fetchAddr", fetchAddr, 32'h500);
    chk("jalr_flush_fetchValid", 32'(fetchValid), 32'd1);
  endtask

  task automatic test_back_to_back();
    logic [31:0] ins, ia;
    int off, kind;
    for (int n = 0; n < 300; n++) begin
      kind = int'($urandom_range(0, 9));
      off = int'($urandom_range(1, 16)) * 4;
      case (kind)
        5: ins = enc_b(13'(off));
        6: ins = enc_b(13'(-off));
        7: ins = enc_j(($urandom_range(0, 1) == 1) ? 21'(off) : 21'(-off));
        8: ins = ($urandom_range(0, 3) == 0) ? JALR : ADDI;
        default: ins = ADDI;
      endcase
      ia = ($urandom_range(0, 9) == 0) ? m_pc + 32'd4 : m_pc;
      if ((m_wait && $urandom_range(0, 3) == 0) || $urandom_range(0, 49) == 0)
        cycle(1'b1, ins, ia, 1'($urandom_range(0, 1)), 1'b1, 32'h1000 + 32'($urandom_range(0, 255)) * 4);
      else
        cycle(1'($urandom_range(0, 3) != 0), ins, ia, 1'($urandom_range(0, 1)), 1'b0, 32'h0);
    end
    repeat (DEPTH + 1) cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
    chk("b2b_drained", 32'(sb.size()), 32'd0);
  endtask

  task automatic test_reset_mid();
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h600);
    repeat (3) cycle(1'b1, ADDI, m_pc, 1'b0, 1'b0, 32'h0);
    resetIn = 1'b1; flushIn = 1'b1; flushPc = 32'h700;
    instrInValid = 1'b1; instrIn = ADDI; instrAddr = m_pc; outReady = 1'b1;
    @(posedge clockIn); #1;
    chk("midrst_fetchValid", 32'(fetchValid), 32'd0);
    chk("midrst_outValid", 32'(outValid), 32'd0);
    chk("midrst_count", 32'(count), 32'd0);
    resetIn = 1'b0; flushIn = 1'b0; instrInValid = 1'b0; outReady = 1'b0;
    #1;
    chk("midrst_fetchAddr", fetchAddr, 32'h100);
    sb.delete(); m_pc = 32'h100; m_count = 0; m_wait = 1'b0;
    repeat (2) cycle(1'b1, ADDI, m_pc, 1'b0, 1'b0, 32'h0);
    repeat (2) cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
  endtask

  initial begin
    test_reset();
    test_fill();
    test_full_simul();
    test_stale();
    test_flush();
    test_branch();
    test_jal_jalr();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
